seg_scan_sched: RTL and testbench

SEG_SCAN_SCHED -- requirements
Module: seg_scan_sched

---
 rtl/seg_scan_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_seg_scan_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_sched.sv
// seg_scan_sched -- six-digit multiplexed 7-segment scan scheduler.
//
// Walks digits 0..5, one per SCAN_DIV-cycle slot, and hands each digit's
// select/segment pattern to an external 74HC595 shifter through a
// tx_start / tx_busy handshake. Frames are double-buffered: load fills a
// shadow copy, and the shadow copy is promoted to the displayed copy only
// when digit 5 completes, so a frame is never torn.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   1 = scan runs, 0 = display blanked
//   data_in    in   [23:0] six hex nibbles, digit k = data_in[4k+3:4k]
//   dp_in      in   [5:0] decimal-point mask, bit k = dp of digit k
//   load       in   one-cycle strobe capturing data_in/dp_in
//   tx_busy    in   shifter busy
//   tx_start   out  one-cycle transfer request
//   sel        out  [5:0] digit select, one-hot active-low
//   seg        out  [7:0] {dp,g,f,e,d,c,b,a}, active-low
//   frame_done out  one-cycle pulse after the digit-5 transfer completes
//   err        out  sticky slot-overrun / busy-timeout flag
module seg_scan_sched #(
  parameter int SCAN_DIV = 50000,
  parameter int BUSY_TO  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] data_in,
  input  logic [5:0]  dp_in,
  input  logic        load,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        err
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int TO_W  = $clog2(BUSY_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, ISSUE, WAIT_BUSY, WAIT_DONE, BLANK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [2:0]        idx_q, idx_d;
  logic [5:0]        sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              err_q, err_d;
  logic              fd_q, fd_d;
  logic              blank_q, blank_d;
  logic [23:0]       shd_data_q, shd_data_d;
  logic [5:0]        shd_dp_q, shd_dp_d;
  logic [23:0]       act_data_q, act_data_d;
  logic [5:0]        act_dp_q, act_dp_d;

  logic              tick;
  logic              done;
  logic [31:0]       data_ext;
  logic [7:0]        dp_ext;
  logic [3:0]        cur_nib;
  logic              cur_dp;

  // Active-low glyph {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Padded copies so that idx values 6/7 index harmlessly.
  assign data_ext = {8'h00, act_data_q};
  assign dp_ext   = {2'b00, act_dp_q};
  assign cur_nib  = data_ext[{idx_q, 2'b00} +: 4];
  assign cur_dp   = dp_ext[idx_q];

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    to_d       = to_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    seg_d      = seg_q;
    err_d      = err_q;
    fd_d       = 1'b0;
    blank_d    = blank_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    done       = 1'b0;

    // Slot counter runs only while enabled so re-enabling starts a full slot.
    if (!en)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;

    if (load) begin
      shd_data_d = data_in;
      shd_dp_d   = dp_in;
    end

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (tick) begin
          sel_d   = ~(6'd1 << idx_q);
          seg_d   = {~cur_dp, hex_glyph(cur_nib)};
          blank_d = 1'b0;
          state_d = ISSUE;
        end else if (!en) begin
          state_d = BLANK;
        end
      end
      BLANK: begin
        sel_d   = 6'h3F;
        seg_d   = 8'hFF;
        blank_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        // Counts cycles elapsed since tx_start; 1 on the first WAIT_BUSY cycle.
        to_d    = TO_W'(1);
        state_d = WAIT_BUSY;
        if (tick) err_d = 1'b1;
      end
      WAIT_BUSY: begin
        if (tick) err_d = 1'b1;
        to_d = to_q + 1'b1;
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_q >= TO_LAST) begin
          err_d = 1'b1;
          done  = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tick) err_d = 1'b1;
        if (!tx_busy) done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (blank_q) begin
        // Blanking transfer: park at digit 0, no frame accounting.
        idx_d   = 3'd0;
        blank_d = 1'b0;
        state_d = IDLE;
      end else begin
        if (idx_q == 3'd5) begin
          idx_d = 3'd0;
          fd_d  = 1'b1;
          // A load coinciding with the wrap bypasses the shadow copy.
          act_data_d = load ? data_in : shd_data_q;
          act_dp_d   = load ? dp_in   : shd_dp_q;
        end else begin
          idx_d = idx_q + 3'd1;
        end
        state_d = en ? WAIT_TICK : BLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      to_q       <= '0;
      idx_q      <= 3'd0;
      sel_q      <= 6'h3F;
      seg_q      <= 8'hFF;
      err_q      <= 1'b0;
      fd_q       <= 1'b0;
      blank_q    <= 1'b0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      err_q      <= err_d;
      fd_q       <= fd_d;
      blank_q    <= blank_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
    end
  end

  assign tx_start   = (state_q == ISSUE);
  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
module tb_seg_scan_sched;
  localparam int SCAN_DIV = 8;
  localparam int BUSY_TO  = 16;

  logic        clk = 1'b0;
  logic        rst, en, load, tx_busy;
  logic [23:0] data_in;
  logic [5:0]  dp_in;
  logic        tx_start, frame_done, err;
  logic [5:0]  sel;
  logic [7:0]  seg;

  seg_scan_sched #(.SCAN_DIV(SCAN_DIV), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in),
    .load(load), .tx_busy(tx_busy), .tx_start(tx_start), .sel(sel),
    .seg(seg), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;
  exp_t q[$];

  // 0 = busy 3 cycles, 1 = never busy, 2 = busy 20 cycles
  int busy_mode = 0;

  int cyc = 0;
  int fd_cnt = 0, fd_last = 0, fd_prev = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done) begin
    fd_prev <= fd_last;
    fd_last <= cyc;
    fd_cnt  <= fd_cnt + 1;
  end

  // Shifter model: busy rises the cycle after tx_start.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start && busy_mode != 1) begin
        @(posedge clk); #1;
        tx_busy = 1'b1;
        repeat ((busy_mode == 2) ? 20 : 3) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] n, input logic dp);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0; 4'h1: g = 8'hF9; 4'h2: g = 8'hA4; 4'h3: g = 8'hB0;
      4'h4: g = 8'h99; 4'h5: g = 8'h92; 4'h6: g = 8'h82; 4'h7: g = 8'hF8;
      4'h8: g = 8'h80; 4'h9: g = 8'h90; 4'hA: g = 8'h88; 4'hB: g = 8'h83;
      4'hC: g = 8'hC6; 4'hD: g = 8'hA1; 4'hE: g = 8'h86; default: g = 8'h8E;
    endcase
    if (dp) g[7] = 1'b0;
    return g;
  endfunction

  function automatic exp_t digit_exp(input logic [23:0] d, input logic [5:0] dpm, input int k);
    exp_t e;
    logic [5:0] one;
    one = 6'd1;
    e.sel = ~(one << k);
    e.seg = glyph(d[4*k +: 4], dpm[k]);
    return e;
  endfunction

  task automatic wait_start(input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (waited < budget) begin
      @(negedge clk);
      waited++;
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    compared++; if (sel !== 6'h3F) begin mismatched++; $display("FAIL reset_sel got %h want 3f", sel); end
    compared++; if (seg !== 8'hFF) begin mismatched++; $display("FAIL reset_seg got %h want ff", seg); end
    compared++; if (tx_start !== 1'b0) begin mismatched++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    bit ok; int w; exp_t e; int fd0;
    @(negedge clk);
    data_in = 24'h123456; dp_in = 6'b000001; load = 1'b1;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++) q.push_back(digit_exp(24'h0, 6'h0, k));
    for (int k = 0; k < 6; k++) q.push_back(digit_exp(24'h123456, 6'b000001, k));
    fd0 = fd_cnt;
    for (int i = 0; i < 12; i++) begin
      wait_start(40, ok, w);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL scan_start[%0d] no tx_start within 40 cycles", i); end
      else begin
        e = q.pop_front();
        compared++; if (sel !== e.sel) begin mismatched++; $display("FAIL scan_sel[%0d] got %h want %h", i, sel, e.sel); end
        compared++; if (seg !== e.seg) begin mismatched++; $display("FAIL scan_seg[%0d] got %h want %h", i, seg, e.seg); end
      end
    end
    repeat (6) @(negedge clk);
    compared++; if (fd_cnt - fd0 != 2) begin mismatched++; $display("FAIL scan_fd_count got %0d want 2", fd_cnt - fd0); end
    compared++; if (fd_last - fd_prev != 48) begin mismatched++; $display("FAIL scan_fd_period got %0d want 48", fd_last - fd_prev); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL scan_err got %b want 0", err); end
  endtask

  task automatic test_midframe_load;
    bit ok; int w; exp_t e;
    q.delete();
    for (int k = 0; k < 2; k++) q.push_back(digit_exp(24'h123456, 6'b000001, k));
    for (int i = 0; i < 12; i++) begin
      wait_start(40, ok, w);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL mid_start[%0d] no tx_start within 40 cycles", i); end
      else begin
        e = q.pop_front();
        compared++; if (sel !== e.sel) begin mismatched++; $display("FAIL mid_sel[%0d] got %h want %h", i, sel, e.sel); end
        compared++; if (seg !== e.seg) begin mismatched++; $display("FAIL mid_seg[%0d] got %h want %h", i, seg, e.seg); end
      end
      if (i == 1) begin
        data_in = 24'hABCDEF; dp_in = 6'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 2; k < 6; k++) q.push_back(digit_exp(24'h123456, 6'b000001, k));
        for (int k = 0; k < 6; k++) q.push_back(digit_exp(24'hABCDEF, 6'h00, k));
      end
    end
  endtask

  task automatic test_timeout;
    bit ok; int w; bit extra; exp_t e;
    busy_mode = 1;
    extra = 1'b0;
    q.delete();
    q.push_back(digit_exp(24'hABCDEF, 6'h00, 0));
    q.push_back(digit_exp(24'hABCDEF, 6'h00, 1));
    wait_start(40, ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL to_start no tx_start within 40 cycles"); end
    e = q.pop_front();
    compared++; if (sel !== e.sel) begin mismatched++; $display("FAIL to_sel got %h want %h", sel, e.sel); end
    compared++; if (seg !== e.seg) begin mismatched++; $display("FAIL to_seg got %h want %h", seg, e.seg); end
    for (int i = 1; i <= BUSY_TO; i++) begin
      @(negedge clk);
      if (tx_start) extra = 1'b1;
      if (i == 7) begin
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL to_err_early got %b want 0", err); end
      end
      if (i == BUSY_TO) begin
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL to_err got %b want 1", err); end
      end
    end
    compared++; if (extra) begin mismatched++; $display("FAIL to_extra_start got 1 want 0"); end
    busy_mode = 0;
    wait_start(40, ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL to_next_start no tx_start within 40 cycles"); end
    e = q.pop_front();
    compared++; if (sel !== e.sel) begin mismatched++; $display("FAIL to_next_sel got %h want %h", sel, e.sel); end
    compared++; if (seg !== e.seg) begin mismatched++; $display("FAIL to_next_seg got %h want %h", seg, e.seg); end
  endtask

  task automatic test_reset_midxfer;
    bit ok; int w; bit stray;
    stray = 1'b0;
    wait_start(40, ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL rstx_start no tx_start within 40 cycles"); end
    compared++; if (sel !== 6'h3B) begin mismatched++; $display("FAIL rstx_pre_sel got %h want 3b", sel); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++; if (sel !== 6'h3F) begin mismatched++; $display("FAIL rstx_sel got %h want 3f", sel); end
    compared++; if (seg !== 8'hFF) begin mismatched++; $display("FAIL rstx_seg got %h want ff", seg); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL rstx_err got %b want 0", err); end
    compared++; if (tx_start !== 1'b0) begin mismatched++; $display("FAIL rstx_tx_start got %b want 0", tx_start); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL rstx_frame_done got %b want 0", frame_done); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (tx_start) stray = 1'b1;
    end
    compared++; if (stray) begin mismatched++; $display("FAIL rstx_early_start got 1 want 0"); end
    @(negedge clk);
    compared++; if (tx_start !== 1'b1) begin mismatched++; $display("FAIL rstx_restart got %b want 1", tx_start); end
    compared++; if (sel !== 6'h3E) begin mismatched++; $display("FAIL rstx_restart_sel got %h want 3e", sel); end
    compared++; if (seg !== 8'hC0) begin mismatched++; $display("FAIL rstx_restart_seg got %h want c0", seg); end
  endtask

  task automatic test_long_busy;
    bit ok; int w; bit stray; bit moved; exp_t e;
    stray = 1'b0; moved = 1'b0;
    repeat (3) @(negedge clk);
    busy_mode = 2;
    q.delete();
    q.push_back(digit_exp(24'h0, 6'h0, 1));
    q.push_back(digit_exp(24'h0, 6'h0, 2));
    wait_start(40, ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL long_start no tx_start within 40 cycles"); end
    e = q.pop_front();
    compared++; if (sel !== e.sel) begin mismatched++; $display("FAIL long_sel got %h want %h", sel, e.sel); end
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (tx_start) stray = 1'b1;
      if (sel !== e.sel || seg !== e.seg) moved = 1'b1;
      if (i == 1) begin
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL long_err_early got %b want 0", err); end
      end
      if (i == 9) begin
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL long_err got %b want 1", err); end
      end
    end
    busy_mode = 0;
    compared++; if (stray) begin mismatched++; $display("FAIL long_extra_start got 1 want 0"); end
    compared++; if (moved) begin mismatched++; $display("FAIL long_sel_seg_changed got 1 want 0"); end
    wait_start(10, ok, w);
    compared++;
    if (!ok || w != 3) begin mismatched++; $display("FAIL long_next_start got ok=%0d after %0d want 3 cycles", ok, w); end
    e = q.pop_front();
    compared++; if (sel !== e.sel) begin mismatched++; $display("FAIL long_next_sel got %h want %h", sel, e.sel); end
  endtask

  task automatic test_en_fall;
    bit ok; int w; bit stray; int fd0;
    stray = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    fd0 = fd_cnt;
    wait_start(20, ok, w);
    compared++;
    if (!ok || w != 4) begin mismatched++; $display("FAIL enf_blank_start got ok=%0d after %0d want 4 cycles", ok, w); end
    compared++; if (sel !== 6'h3F) begin mismatched++; $display("FAIL enf_blank_sel got %h want 3f", sel); end
    compared++; if (seg !== 8'hFF) begin mismatched++; $display("FAIL enf_blank_seg got %h want ff", seg); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_start) stray = 1'b1;
    end
    compared++; if (stray) begin mismatched++; $display("FAIL enf_idle_start got 1 want 0"); end
    compared++; if (fd_cnt != fd0) begin mismatched++; $display("FAIL enf_frame_done got %0d pulses want 0", fd_cnt - fd0); end
    en = 1'b1;
    wait_start(40, ok, w);
    compared++;
    if (!ok || w != SCAN_DIV) begin mismatched++; $display("FAIL enf_restart got ok=%0d after %0d want %0d cycles", ok, w, SCAN_DIV); end
    compared++; if (sel !== 6'h3E) begin mismatched++; $display("FAIL enf_restart_sel got %h want 3e", sel); end
    compared++; if (seg !== 8'hC0) begin mismatched++; $display("FAIL enf_restart_seg got %h want c0", seg); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_timeout();
    test_reset_midxfer();
    test_long_busy();
    test_en_fall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
